// File: rtl/flit_compressor_pipe.sv
// Two-stage pipelined flit compressor: S1 classifies each word, S2 packs the payloads LSB-first.
// Valid/ready on both sides; head flits pass through uncompressed.
module flit_compressor_pipe #(
  parameter  int FLIT_W   = 128,
  parameter  int WORD_W   = 32,
  parameter  int NARROW_W = 8,
  parameter  int CNT_W    = 16,
  localparam int N_WORDS  = FLIT_W / WORD_W,
  localparam int LEN_W    = $clog2(FLIT_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLIT_W-1:0]    data_in,
  input  logic                 is_head,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLIT_W-1:0]    data_out,
  output logic [2*N_WORDS-1:0] en_out,
  output logic [LEN_W-1:0]     comp_len,
  output logic                 is_head_out,
  output logic [CNT_W-1:0]     comp_cnt
);

  localparam logic [1:0] CODE_RAW    = 2'b00;
  localparam logic [1:0] CODE_ZERO   = 2'b01;
  localparam logic [1:0] CODE_NARROW = 2'b10;
  localparam logic [1:0] CODE_REPEAT = 2'b11;

  logic                 r_s1Full;
  logic [FLIT_W-1:0]    r_s1Data;
  logic [2*N_WORDS-1:0] r_s1Codes;
  logic                 r_s1Head;

  logic                 w_s1Load;
  logic                 w_s2Load;
  logic [WORD_W-1:0]    w_words [N_WORDS];
  logic [2*N_WORDS-1:0] w_codes;
  logic [FLIT_W-1:0]    w_packed;
  logic [LEN_W-1:0]     w_len;

  // Narrow means the word is sign-extendable from NARROW_W bits.
  function automatic logic [1:0] classify(input logic [WORD_W-1:0] cur,
                                          input logic [WORD_W-1:0] prev,
                                          input logic              hasPrev);
    logic [WORD_W-NARROW_W:0] top;
    top = cur[WORD_W-1:NARROW_W-1];
    if (cur == '0)                return CODE_ZERO;
    if (hasPrev && cur == prev)   return CODE_REPEAT;
    if (top == '0 || top == '1)   return CODE_NARROW;
    return CODE_RAW;
  endfunction

  assign w_s2Load = r_s1Full && (!out_valid || out_ready);
  assign in_ready = !rst && (!r_s1Full || w_s2Load);
  assign w_s1Load = in_valid && in_ready;

  always_comb begin
    w_codes = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      w_words[i] = data_in[i*WORD_W +: WORD_W];
    end
    for (int i = 0; i < N_WORDS; i++) begin
      if (!is_head) begin
        w_codes[2*i +: 2] = classify(w_words[i], w_words[(i == 0) ? 0 : i-1], i != 0);
      end
    end
  end

  // Head flits carry all-raw codes, so packing reproduces the flit with full length.
  always_comb begin
    w_packed = '0;
    w_len    = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      case (r_s1Codes[2*i +: 2])
        CODE_RAW: begin
          w_packed = w_packed | (FLIT_W'(r_s1Data[i*WORD_W +: WORD_W]) << w_len);
          w_len    = w_len + LEN_W'(WORD_W);
        end
        CODE_NARROW: begin
          w_packed = w_packed | (FLIT_W'(r_s1Data[i*WORD_W +: NARROW_W]) << w_len);
          w_len    = w_len + LEN_W'(NARROW_W);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Full    <= 1'b0;
      r_s1Data    <= '0;
      r_s1Codes   <= '0;
      r_s1Head    <= 1'b0;
      out_valid   <= 1'b0;
      data_out    <= '0;
      en_out      <= '0;
      comp_len    <= '0;
      is_head_out <= 1'b0;
      comp_cnt    <= '0;
    end else begin
      if (w_s1Load) begin
        r_s1Full  <= 1'b1;
        r_s1Data  <= data_in;
        r_s1Codes <= w_codes;
        r_s1Head  <= is_head;
      end else if (w_s2Load) begin
        r_s1Full  <= 1'b0;
      end

      if (w_s2Load) begin
        out_valid   <= 1'b1;
        data_out    <= w_packed;
        en_out      <= r_s1Codes;
        comp_len    <= w_len;
        is_head_out <= r_s1Head;
        if (!r_s1Head && w_len < LEN_W'(FLIT_W) && comp_cnt != '1) begin
          comp_cnt <= comp_cnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flit_compressor_pipe.sv
// Randomized scoreboard bench for flit_compressor_pipe: a bit-queue reference model predicts
// every output, a monitor pops and compares whenever an output transfer happens.
module tb_flit_compressor_pipe;

  localparam int FW = 128;
  localparam int WW = 32;
  localparam int NW = 8;
  localparam int NWORDS = FW / WW;

  typedef struct packed {
    logic [FW-1:0]       data;
    logic [2*NWORDS-1:0] en;
    logic [7:0]          len;
    logic                head;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FW-1:0]     data_in = '0;
  logic              is_head = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [FW-1:0]     data_out;
  logic [2*NWORDS-1:0] en_out;
  logic [7:0]        comp_len;
  logic              is_head_out;
  logic [15:0]       comp_cnt;

  exp_t        sb[$];
  int          totalChecks = 0;
  int          badChecks = 0;
  int          cycle = 0;
  int          acceptCycle = 0;
  int          lastOutCycle = 0;
  int          acceptedCount = 0;
  logic [15:0] modelCnt = '0;
  exp_t        lastOut;
  logic [15:0] lastCnt;
  bit          senderDone;
  bit          bpRun;

  flit_compressor_pipe #(.FLIT_W(FW), .WORD_W(WW), .NARROW_W(NW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .is_head(is_head), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .en_out(en_out), .comp_len(comp_len),
    .is_head_out(is_head_out), .comp_cnt(comp_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: classify each word by its numeric value, then append payload bits to a queue.
  function automatic exp_t refModel(input logic [FW-1:0] d, input logic h);
    exp_t        e;
    bit          bits[$];
    logic [WW-1:0] words[NWORDS];
    int          sv;
    e = '0;
    e.head = h;
    for (int i = 0; i < NWORDS; i++) words[i] = d[i*WW +: WW];
    for (int i = 0; i < NWORDS; i++) begin
      sv = $signed(words[i]);
      if (h) begin
        for (int b = 0; b < WW; b++) bits.push_back(words[i][b]);
      end else if (words[i] == 0) begin
        e.en[2*i +: 2] = 2'b01;
      end else if (i > 0 && words[i] == words[i-1]) begin
        e.en[2*i +: 2] = 2'b11;
      end else if (sv >= -(1 << (NW-1)) && sv <= (1 << (NW-1)) - 1) begin
        e.en[2*i +: 2] = 2'b10;
        for (int b = 0; b < NW; b++) bits.push_back(words[i][b]);
      end else begin
        for (int b = 0; b < WW; b++) bits.push_back(words[i][b]);
      end
    end
    e.len = 8'(bits.size());
    for (int k = 0; k < bits.size(); k++) e.data[k] = bits[k];
    return e;
  endfunction

  function automatic logic [FW-1:0] genFlit();
    logic [FW-1:0] f;
    logic [WW-1:0] w;
    logic [7:0]    b;
    f = '0;
    for (int i = 0; i < NWORDS; i++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 4))
        0: w = '0;
        1: w = (i > 0) ? f[(i-1)*WW +: WW] : $urandom;
        2: w = {{(WW-8){b[7]}}, b};
        3: w = {{(WW-8){~b[7]}}, b};
        default: w = $urandom;
      endcase
      f[i*WW +: WW] = w;
    end
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; holds in_valid until the flit is taken.
  task automatic applyStimulus(input logic [FW-1:0] d, input logic h);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    data_in  = d;
    is_head  = h;
    for (int c = 0; c < 500 && !acc; c++) begin
      #4;
      if (in_ready) begin
        acc = 1;
        acceptCycle = cycle;
        acceptedCount++;
        sb.push_back(refModel(d, h));
      end
      @(negedge clk);
    end
    if (!acc) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    is_head  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 2000 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", FW'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every output transfer must match the oldest predicted flit.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        if (!e.head && e.len < FW && modelCnt != 16'hFFFF) modelCnt = modelCnt + 1'b1;
        checkOutput("data_out", data_out, e.data);
        checkOutput("en_out", FW'(en_out), FW'(e.en));
        checkOutput("comp_len", FW'(comp_len), FW'(e.len));
        checkOutput("is_head_out", FW'(is_head_out), FW'(e.head));
        checkOutput("comp_cnt", FW'(comp_cnt), FW'(modelCnt));
        lastOut.data = data_out;
        lastOut.en   = en_out;
        lastOut.len  = comp_len;
        lastOut.head = is_head_out;
        lastCnt      = comp_cnt;
        lastOutCycle = cycle;
      end
    end
  end

  initial begin
    logic [FW-1:0] f1;
    f1 = 128'h0000000000000000_FAC68915ACEF098F;

    repeat (2) @(negedge clk);
    #4;
    checkOutput("rst_out_valid", FW'(out_valid), 0);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_en_out", FW'(en_out), 0);
    checkOutput("rst_comp_len", FW'(comp_len), 0);
    checkOutput("rst_is_head_out", FW'(is_head_out), 0);
    checkOutput("rst_comp_cnt", FW'(comp_cnt), 0);
    checkOutput("rst_in_ready", FW'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #4;
    checkOutput("post_rst_in_ready", FW'(in_ready), 1);
    @(negedge clk);

    $display("[TB] directed flits");
    applyStimulus(f1, 1'b0);
    idle();
    waitDrain();
    checkOutput("latency", FW'(lastOutCycle - acceptCycle), 2);
    checkOutput("t1_en", FW'(lastOut.en), 128'h50);
    checkOutput("t1_len", FW'(lastOut.len), 64);
    checkOutput("t1_data", lastOut.data, 128'hFAC68915ACEF098F);
    checkOutput("t1_cnt", FW'(lastCnt), 1);

    applyStimulus(128'h12345678_12345678_12345678_0000007F, 1'b0);
    idle();
    waitDrain();
    checkOutput("t2_en", FW'(lastOut.en), 128'hF2);
    checkOutput("t2_len", FW'(lastOut.len), 40);
    checkOutput("t2_data", lastOut.data, 128'h12345678_7F);

    applyStimulus(128'hFFFFFF85_00000000_FFFFFF85_FFFFFF85, 1'b0);
    idle();
    waitDrain();
    checkOutput("t3_en", FW'(lastOut.en), 128'h9E);
    checkOutput("t3_len", FW'(lastOut.len), 16);
    checkOutput("t3_data", lastOut.data, 128'h8585);

    applyStimulus(f1, 1'b1);
    idle();
    waitDrain();
    checkOutput("t4_en", FW'(lastOut.en), 0);
    checkOutput("t4_len", FW'(lastOut.len), 128);
    checkOutput("t4_data", lastOut.data, f1);
    checkOutput("t4_head", FW'(lastOut.head), 1);
    checkOutput("t4_cnt", FW'(lastCnt), 3);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    acceptedCount = 0;
    senderDone = 0;
    fork
      begin
        for (int k = 0; k < 5; k++) applyStimulus(genFlit(), 1'b0);
        idle();
        senderDone = 1;
      end
    join_none
    repeat (8) @(negedge clk);
    #4;
    checkOutput("bp_accepted", FW'(acceptedCount), 2);
    checkOutput("bp_in_ready", FW'(in_ready), 0);
    checkOutput("bp_out_valid", FW'(out_valid), 1);
    checkOutput("bp_hold_data", data_out, sb[0].data);
    checkOutput("bp_hold_en", FW'(en_out), FW'(sb[0].en));
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #4;
      checkOutput("bp_no_gap", FW'(out_valid), 1);
      @(negedge clk);
    end
    for (int c = 0; c < 100 && !senderDone; c++) @(negedge clk);
    checkOutput("bp_sender_done", FW'(senderDone), 1);
    waitDrain();

    $display("[TB] reset with flits in flight");
    out_ready = 1'b0;
    applyStimulus(genFlit(), 1'b0);
    applyStimulus(genFlit(), 1'b0);
    idle();
    rst = 1'b1;
    #4;
    checkOutput("inrst_in_ready", FW'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    modelCnt = '0;
    #4;
    checkOutput("midrst_out_valid", FW'(out_valid), 0);
    checkOutput("midrst_comp_cnt", FW'(comp_cnt), 0);
    checkOutput("midrst_in_ready", FW'(in_ready), 1);
    @(negedge clk);

    $display("[TB] random traffic");
    bpRun = 1;
    fork
      while (bpRun) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
    join_none
    for (int k = 0; k < 400; k++) begin
      applyStimulus(genFlit(), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end
    end
    idle();
    bpRun = 0;
    @(negedge clk);
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] counter saturation");
    for (int k = 0; k < 65600; k++) begin
      logic [FW-1:0] f;
      f = genFlit();
      f[WW-1:0] = '0;
      applyStimulus(f, 1'b0);
    end
    idle();
    waitDrain();
    checkOutput("cnt_saturated", FW'(comp_cnt), 128'hFFFF);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
